// File: rtl/vga_image_fetch_if.sv
// ROM read bus and VGA pin bundle for vga_image_fetch.
// The master side drives the ROM address and the DAC pins.
interface vga_image_fetch_if;
  logic [31:0] rom_addr;
  logic [23:0] rom_r;
  logic [23:0] rom_g;
  logic [23:0] rom_b;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        blank_n;

  modport master (
    output rom_addr, vga_r, vga_g, vga_b,
    output hsync, vsync, blank_n,
    input  rom_r, rom_g, rom_b
  );

  modport slave (
    input  rom_addr, vga_r, vga_g, vga_b,
    input  hsync, vsync, blank_n,
    output rom_r, rom_g, rom_b
  );
endinterface

// File: rtl/vga_image_fetch.sv
// VGA timing + image ROM address generator with 2-tick pixel pipeline.
// Optional VGA_TESTPAT_EN adds a testpat input that overrides window pixels.
module vga_image_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 400,
  parameter int IMG_H    = 400,
  parameter int IMG_X0   = 120,
  parameter int IMG_Y0   = 40,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
`ifdef VGA_TESTPAT_EN
  input  logic testpat,
`endif
  vga_image_fetch_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int AW = $clog2(DEPTH);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_BEG  = HW'(IMG_X0);
  localparam logic [HW-1:0] X_END  = HW'(IMG_X0 + IMG_W);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_BEG  = VW'(IMG_Y0);
  localparam logic [VW-1:0] Y_END  = VW'(IMG_Y0 + IMG_H);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [AW-1:0] addr_cnt_q, addr_cnt_d;
  logic [31:0]   rom_addr_q, rom_addr_d;
  logic          win1_q, win1_d;
  logic          act1_q, act1_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          blank_q, blank_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
`ifdef VGA_TESTPAT_EN
  logic [7:0]    hx1_q, hx1_d;
  logic [7:0]    vy1_q, vy1_d;
`endif

  logic          in_win, act, hs, vs;
  logic          h_wrap, f_wrap;
  logic [23:0]   pix;
  logic          unused_rom;

  assign unused_rom = ^{bus.rom_r[23:8], bus.rom_g[23:8], bus.rom_b[23:8]};

  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    addr_cnt_d = addr_cnt_q;
    rom_addr_d = rom_addr_q;
    win1_d     = win1_q;
    act1_d     = act1_q;
    hs1_d      = hs1_q;
    vs1_d      = vs1_q;
    rgb_d      = rgb_q;
    blank_d    = blank_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
`ifdef VGA_TESTPAT_EN
    hx1_d      = hx1_q;
    vy1_d      = vy1_q;
`endif
    in_win = (hcnt_q >= X_BEG) && (hcnt_q < X_END) &&
             (vcnt_q >= Y_BEG) && (vcnt_q < Y_END);
    act    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs     = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs     = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    h_wrap = (hcnt_q == H_LAST);
    f_wrap = h_wrap && (vcnt_q == V_LAST);

    // ROM data was captured one clk after the previous tick
    if (win1_q) begin
      pix = {bus.rom_r[7:0], bus.rom_g[7:0], bus.rom_b[7:0]};
`ifdef VGA_TESTPAT_EN
      if (testpat) pix = {hx1_q, vy1_q, 8'hFF};
`endif
    end else if (act1_q) begin
      pix = BG_COLOR;
    end else begin
      pix = '0;
    end

    if (pix_en) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
      if (h_wrap) vcnt_d = f_wrap ? '0 : vcnt_q + VW'(1);
      if (in_win) begin
        rom_addr_d = 32'(addr_cnt_q);
        addr_cnt_d = (addr_cnt_q == A_LAST) ? '0 : addr_cnt_q + AW'(1);
      end
      if (f_wrap) addr_cnt_d = '0;
      win1_d  = in_win;
      act1_d  = act;
      hs1_d   = hs;
      vs1_d   = vs;
`ifdef VGA_TESTPAT_EN
      hx1_d   = 8'(hcnt_q);
      vy1_d   = 8'(vcnt_q);
`endif
      rgb_d   = pix;
      blank_d = act1_q;
      hsync_d = hs1_q;
      vsync_d = vs1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      addr_cnt_q <= '0;
      rom_addr_q <= '0;
      win1_q     <= 1'b0;
      act1_q     <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      rgb_q      <= '0;
      blank_q    <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
`ifdef VGA_TESTPAT_EN
      hx1_q      <= '0;
      vy1_q      <= '0;
`endif
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      addr_cnt_q <= addr_cnt_d;
      rom_addr_q <= rom_addr_d;
      win1_q     <= win1_d;
      act1_q     <= act1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      rgb_q      <= rgb_d;
      blank_q    <= blank_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
`ifdef VGA_TESTPAT_EN
      hx1_q      <= hx1_d;
      vy1_q      <= vy1_d;
`endif
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.vga_r    = rgb_q[23:16];
  assign bus.vga_g    = rgb_q[15:8];
  assign bus.vga_b    = rgb_q[7:0];
  assign bus.blank_n  = blank_q;
  assign bus.hsync    = hsync_q;
  assign bus.vsync    = vsync_q;
endmodule
